baud_gen_frac: RTL and testbench
================================

# baud_gen_frac

Parametrised fractional baud-rate generator for the UART. It produces an oversampled tick (`ce_ovs`) and a bit-rate tick (`ce_1`) from a single system clock, with widths and oversampling factor set by parameters. Its divider settings are loaded at run time through a valid/ready handshake and applied glitch-free on a bit boundary. It sits between the register block and the UART TX/RX engines and replaces the fixed ×16 generator for new designs.

## Interface
- `FREQ_W`, 12: width of `cfg_freq`; must be ≤ `LIMIT_W`.
- `LIMIT_W`, 16: width of `cfg_limit`.
- `OVS`, 16: oversampling factor, ≥ 2; `ce_1` = `ce_ovs` / `OVS`.
- `clock`  in  1  system clock; all logic on its rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `enable`  in  1  run the generator; 0 freezes accumulator and phase and masks ticks.
- `cfg_valid`  in  1  new divider pair offered.
- `cfg_ready`  out  1  generator can accept a divider pair.
- `cfg_freq`  in  FREQ_W  baud_freq = OVS·baud / gcd(f_clk, OVS·baud).
- `cfg_limit`  in  LIMIT_W  baud_limit = f_clk / gcd(f_clk, OVS·baud) − baud_freq.
- `sync`  in  1  phase restart request (RX start-bit alignment).
- `ce_ovs`  out  1  oversampled tick, one cycle wide.
- `ce_1`  out  1  bit tick, one cycle wide, coincident with the last `ce_ovs` of a bit.
- `phase`  out  $clog2(OVS)  index of the current oversample within the bit.
- `cfg_pending`  out  1  an accepted pair is waiting to be applied.

## Operation
- Active registers `freq_q`, `limit_q`; shadow registers `freq_s`, `limit_s`; accumulator `acc` of width LIMIT_W+1. Intermediate results never overflow.
- Each enabled cycle: if `acc ≥ limit_q`, then `acc ← acc − limit_q` and `ce_ovs` is set next cycle. Otherwise `acc ← acc + freq_q` and `ce_ovs` is cleared.
- `phase` increments on each `ce_ovs`; wraps OVS−1 → 0. `ce_1` asserts on the `ce_ovs` whose pre-increment phase is OVS−1.
- States:
  - STOP: `enable` = 0; ticks 0.
  - RUN: `enable` = 1, no pending pair.
  - PEND: `enable` = 1, pair held in shadow.
- Handshake: transfer occurs when `cfg_valid & cfg_ready`. `cfg_ready` = 1 in STOP and RUN, 0 in PEND.
- Transfer in STOP: applied the next cycle. Active registers are loaded, `acc` ← 0, `phase` ← 0.
- Transfer in RUN: go to PEND. Apply on the cycle `ce_1` is asserted, with the same load and clears. Then return to RUN.
- `enable` falling while in PEND: apply immediately and go to STOP.
- Degenerate settings:
  - `limit_q` = 0: `ce_ovs` every cycle.
  - `freq_q` = 0 with `limit_q` > 0: no ticks ever.
  - Both are legal; neither hangs the handshake in STOP.
- Reset values: `acc` 0, `phase` 0, `freq_q` 0, `limit_q` all-ones, `ce_ovs` 0, `ce_1` 0, `cfg_ready` 1, `cfg_pending` 0, state STOP. The generator is silent until the first configuration.

## Timing
- Tick latency is one cycle: `ce_ovs` is registered from the `acc ≥ limit_q` compare of the previous cycle.
- `ce_1` and `phase` are registered alongside `ce_ovs`.
- The first `ce_ovs` after applying (freq, limit) occurs ⌈limit/freq⌉+1 cycles after the apply edge.
- `enable` = 0 clears `ce_ovs` and `ce_1` on the next edge. `acc` and `phase` hold their values.
- `sync` and an apply in the same cycle: the apply wins; both clear `acc` and `phase` anyway.
- `reset` mid-operation discards any pending pair.

## Configuration
- `BAUD_GEN_SYNC_EN` defined:
  - `sync` = 1 clears `acc` and `phase` to 0 on the next edge.
  - It also forces `ce_ovs` and `ce_1` to 0 on that edge.
  - Counting resumes the following cycle, so the first `ce_ovs` lands ⌈limit/freq⌉+1 cycles after `sync`.
- Not defined: the `sync` port exists but is ignored, and no sync logic is synthesised.

## Test plan
- 50 MHz clock, 115200 baud, OVS = 16: load freq = 576, limit = 15049 → exactly 576 `ce_ovs` and 36 `ce_1` in every 15625-cycle window after the first apply.
- Reset, then `enable` = 1 without configuration → no ticks for 100 000 cycles. `cfg_ready` = 1 and `cfg_pending` = 0 throughout.
- Running at 576/15049, offer 1152/14473 mid-bit → `cfg_ready` drops and `cfg_pending` = 1 until the next `ce_1`. The pair applies on that cycle and the rate then doubles (72 `ce_1` per 15625 cycles).
- limit = 0, freq = 1 → `ce_ovs` every cycle and `ce_1` every 16th cycle. Toggling `enable` low then high resumes from the held `phase`.
- With `BAUD_GEN_SYNC_EN`, pulse `sync` at `phase` = 7 → the next edge shows `phase` = 0 and ticks low. The next `ce_ovs` arrives ⌈15049/576⌉+1 = 28 cycles after the pulse.
- Assert `reset` while in PEND → next cycle: state STOP, `cfg_pending` 0, `cfg_ready` 1, all ticks 0.

Source files
------------

// File: rtl/baud_gen_frac.sv
// Fractional baud generator: oversample tick, bit tick, handshaked divider load.
// Optional `BAUD_GEN_SYNC_EN enables phase restart through the sync input.
module baud_gen_frac #(
  parameter int FREQ_W  = 12,
  parameter int LIMIT_W = 16,
  parameter int OVS     = 16
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   enable,
  input  logic                   cfg_valid,
  output logic                   cfg_ready,
  input  logic [FREQ_W-1:0]      cfg_freq,
  input  logic [LIMIT_W-1:0]     cfg_limit,
  input  logic                   sync,
  output logic                   ce_ovs,
  output logic                   ce_1,
  output logic [$clog2(OVS)-1:0] phase,
  output logic                   cfg_pending
);

  localparam int AW = LIMIT_W + 1;
  localparam int PW = $clog2(OVS);
  localparam logic [PW-1:0] LAST = PW'(OVS - 1);

  typedef enum logic [1:0] {
    STOP = 2'd0,
    RUN  = 2'd1,
    PEND = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [FREQ_W-1:0]  freq_q, freq_d;
  logic [LIMIT_W-1:0] limit_q, limit_d;
  logic [FREQ_W-1:0]  freq_s_q, freq_s_d;
  logic [LIMIT_W-1:0] limit_s_q, limit_s_d;
  logic [AW-1:0]      acc_q, acc_d;
  logic [PW-1:0]      phase_q, phase_d;
  logic               ce_ovs_q, ce_ovs_d;
  logic               ce_1_q, ce_1_d;

  logic xfer;
  logic ld_cfg;
  logic ld_sh;
  logic store_sh;
  logic apply;
  logic clr;
  logic tick;
  logic sync_clr;

`ifdef BAUD_GEN_SYNC_EN
  assign sync_clr = sync;
`else
  logic unused_sync;
  assign sync_clr    = 1'b0;
  assign unused_sync = sync;
`endif

  assign cfg_ready   = (state_q != PEND);
  assign cfg_pending = (state_q == PEND);
  assign ce_ovs      = ce_ovs_q;
  assign ce_1        = ce_1_q;
  assign phase       = phase_q;

  assign xfer = cfg_valid & cfg_ready;

  // Disabling behaves as STOP at once: any held or offered pair applies now
  always_comb begin
    state_d  = state_q;
    ld_cfg   = 1'b0;
    ld_sh    = 1'b0;
    store_sh = 1'b0;
    if (!enable) begin
      state_d = STOP;
      if (state_q == PEND) begin
        ld_sh = 1'b1;
      end else if (xfer) begin
        ld_cfg = 1'b1;
      end
    end else begin
      unique case (state_q)
        STOP: begin
          state_d = RUN;
          ld_cfg  = xfer;
        end
        RUN: begin
          if (xfer) begin
            store_sh = 1'b1;
            state_d  = PEND;
          end
        end
        PEND: begin
          if (ce_1_q) begin
            ld_sh   = 1'b1;
            state_d = RUN;
          end
        end
        default: state_d = STOP;
      endcase
    end
  end

  assign apply = ld_cfg | ld_sh;
  assign clr   = apply | sync_clr;

  always_comb begin
    freq_d    = freq_q;
    limit_d   = limit_q;
    freq_s_d  = freq_s_q;
    limit_s_d = limit_s_q;
    if (ld_cfg) begin
      freq_d  = cfg_freq;
      limit_d = cfg_limit;
    end else if (ld_sh) begin
      freq_d  = freq_s_q;
      limit_d = limit_s_q;
    end
    if (store_sh) begin
      freq_s_d  = cfg_freq;
      limit_s_d = cfg_limit;
    end
  end

  assign tick = (acc_q >= AW'(limit_q));

  always_comb begin
    acc_d    = acc_q;
    phase_d  = phase_q;
    ce_ovs_d = 1'b0;
    ce_1_d   = 1'b0;
    if (clr) begin
      acc_d   = '0;
      phase_d = '0;
    end else if (enable) begin
      if (tick) begin
        acc_d    = acc_q - AW'(limit_q);
        ce_ovs_d = 1'b1;
        ce_1_d   = (phase_q == LAST);
        phase_d  = (phase_q == LAST) ? '0 : phase_q + PW'(1);
      end else begin
        acc_d = acc_q + AW'(freq_q);
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= STOP;
      freq_q    <= '0;
      limit_q   <= '1;
      freq_s_q  <= '0;
      limit_s_q <= '1;
      acc_q     <= '0;
      phase_q   <= '0;
      ce_ovs_q  <= 1'b0;
      ce_1_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      freq_q    <= freq_d;
      limit_q   <= limit_d;
      freq_s_q  <= freq_s_d;
      limit_s_q <= limit_s_d;
      acc_q     <= acc_d;
      phase_q   <= phase_d;
      ce_ovs_q  <= ce_ovs_d;
      ce_1_q    <= ce_1_d;
    end
  end

endmodule

// File: tb/tb_baud_gen_frac.sv
// Directed bench for baud_gen_frac: vector table plus multi-cycle sequences.
// Sync sequence expectations follow `BAUD_GEN_SYNC_EN.
module tb_baud_gen_frac;

  localparam int FW = 12;
  localparam int LW = 16;
  localparam int PW = 4;

  logic          clock = 1'b0;
  logic          reset;
  logic          enable;
  logic          cfg_valid;
  logic          cfg_ready;
  logic [FW-1:0] cfg_freq;
  logic [LW-1:0] cfg_limit;
  logic          sync;
  logic          ce_ovs;
  logic          ce_1;
  logic [PW-1:0] phase;
  logic          cfg_pending;

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  baud_gen_frac #(
    .FREQ_W (FW),
    .LIMIT_W(LW),
    .OVS    (16)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .enable     (enable),
    .cfg_valid  (cfg_valid),
    .cfg_ready  (cfg_ready),
    .cfg_freq   (cfg_freq),
    .cfg_limit  (cfg_limit),
    .sync       (sync),
    .ce_ovs     (ce_ovs),
    .ce_1       (ce_1),
    .phase      (phase),
    .cfg_pending(cfg_pending)
  );

  typedef struct {
    logic          en;
    logic          vld;
    logic [FW-1:0] f;
    logic [LW-1:0] l;
    logic          ovs;
    logic          c1;
    logic [PW-1:0] ph;
    logic          rdy;
    logic          pnd;
  } vec_t;

  vec_t tv[14];

  function automatic vec_t mkv(
    input logic en, input logic vld,
    input int f, input int l,
    input logic ovs, input logic c1,
    input int ph, input logic rdy,
    input logic pnd
  );
    vec_t v;
    v.en  = en;
    v.vld = vld;
    v.f   = FW'(f);
    v.l   = LW'(l);
    v.ovs = ovs;
    v.c1  = c1;
    v.ph  = PW'(ph);
    v.rdy = rdy;
    v.pnd = pnd;
    return v;
  endfunction

  task automatic chk(
    input string nm,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", nm, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset     = 1'b1;
    cfg_valid = 1'b0;
    sync      = 1'b0;
    step();
    step();
    reset = 1'b0;
  endtask

  task automatic wait_phase(
    input int ph, input int budget,
    input string nm
  );
    int n;
    n = 0;
    while (phase != PW'(ph) && n < budget) begin
      step();
      n++;
    end
    if (phase != PW'(ph)) chk(nm, 32'(phase), 32'(ph));
  endtask

  task automatic load_run(input int f, input int l);
    enable    = 1'b1;
    cfg_valid = 1'b1;
    cfg_freq  = FW'(f);
    cfg_limit = LW'(l);
    step();
    cfg_valid = 1'b0;
  endtask

  initial begin
    int n;
    int novs;
    int nc1;
    int bad;
    logic [PW-1:0] ph0;

    enable    = 1'b0;
    cfg_valid = 1'b0;
    cfg_freq  = '0;
    cfg_limit = '0;
    sync      = 1'b0;
    do_reset();

    chk("rst.ovs", 32'(ce_ovs), 0);
    chk("rst.c1", 32'(ce_1), 0);
    chk("rst.ph", 32'(phase), 0);
    chk("rst.rdy", 32'(cfg_ready), 1);
    chk("rst.pnd", 32'(cfg_pending), 0);

    // freq 1 / limit 2: tick every 3rd cycle; then a pending 2/0 pair
    tv[0]  = mkv(0, 1, 1, 2, 0, 0, 0, 1, 0);
    tv[1]  = mkv(1, 0, 0, 0, 0, 0, 0, 1, 0);
    tv[2]  = mkv(1, 0, 0, 0, 0, 0, 0, 1, 0);
    tv[3]  = mkv(1, 0, 0, 0, 1, 0, 1, 1, 0);
    tv[4]  = mkv(1, 0, 0, 0, 0, 0, 1, 1, 0);
    tv[5]  = mkv(1, 0, 0, 0, 0, 0, 1, 1, 0);
    tv[6]  = mkv(1, 0, 0, 0, 1, 0, 2, 1, 0);
    tv[7]  = mkv(0, 0, 0, 0, 0, 0, 2, 1, 0);
    tv[8]  = mkv(0, 0, 0, 0, 0, 0, 2, 1, 0);
    tv[9]  = mkv(1, 0, 0, 0, 0, 0, 2, 1, 0);
    tv[10] = mkv(1, 1, 2, 0, 0, 0, 2, 0, 1);
    tv[11] = mkv(1, 1, 2, 0, 1, 0, 3, 0, 1);
    tv[12] = mkv(0, 0, 0, 0, 0, 0, 0, 1, 0);
    tv[13] = mkv(1, 0, 0, 0, 1, 0, 1, 1, 0);

    for (int i = 0; i < 14; i++) begin
      enable    = tv[i].en;
      cfg_valid = tv[i].vld;
      cfg_freq  = tv[i].f;
      cfg_limit = tv[i].l;
      step();
      chk($sformatf("v%0d.ovs", i), 32'(ce_ovs), 32'(tv[i].ovs));
      chk($sformatf("v%0d.c1", i), 32'(ce_1), 32'(tv[i].c1));
      chk($sformatf("v%0d.ph", i), 32'(phase), 32'(tv[i].ph));
      chk($sformatf("v%0d.rdy", i), 32'(cfg_ready), 32'(tv[i].rdy));
      chk($sformatf("v%0d.pnd", i), 32'(cfg_pending), 32'(tv[i].pnd));
    end
    cfg_valid = 1'b0;

    // limit 0: tick every cycle, bit tick when phase wraps
    for (int p = 2; p < 16; p++) begin
      step();
      chk($sformatf("l0.ph%0d", p), 32'(phase), 32'(p));
      chk($sformatf("l0.ovs%0d", p), 32'(ce_ovs), 1);
      chk($sformatf("l0.c1_%0d", p), 32'(ce_1), 0);
    end
    step();
    chk("l0.wrap.c1", 32'(ce_1), 1);
    chk("l0.wrap.ph", 32'(phase), 0);
    step();
    chk("l0.ph1", 32'(phase), 1);
    enable = 1'b0;
    step();
    chk("hold.ovs", 32'(ce_ovs), 0);
    chk("hold.ph", 32'(phase), 1);
    step();
    chk("hold2.ph", 32'(phase), 1);
    enable = 1'b1;
    step();
    chk("resume.ph", 32'(phase), 2);
    chk("resume.ovs", 32'(ce_ovs), 1);

    // unconfigured generator stays silent
    do_reset();
    enable = 1'b1;
    novs = 0;
    bad  = 0;
    for (int i = 0; i < 2000; i++) begin
      step();
      if (ce_ovs || ce_1) novs++;
      if (!cfg_ready || cfg_pending) bad++;
    end
    chk("silent.ticks", 32'(novs), 0);
    chk("silent.hs", 32'(bad), 0);

    // 576/15049: first tick latency and per-window counts
    do_reset();
    load_run(576, 15049);
    n    = 0;
    novs = 0;
    nc1  = 0;
    while (!ce_ovs && n < 100) begin
      step();
      n++;
    end
    chk("first.lat", 32'(n), 28);
    for (int i = n; i <= 15625; i++) begin
      if (i != n) step();
      if (ce_ovs) novs++;
      if (ce_1) nc1++;
    end
    chk("win.ovs", 32'(novs), 576);
    chk("win.c1", 32'(nc1), 36);

    // mid-bit offer of 1152/14473 waits for the next bit tick
    wait_phase(5, 400, "mid.wait");
    cfg_valid = 1'b1;
    cfg_freq  = FW'(1152);
    cfg_limit = LW'(14473);
    step();
    cfg_valid = 1'b0;
    chk("offer.rdy", 32'(cfg_ready), 0);
    chk("offer.pnd", 32'(cfg_pending), 1);
    n   = 0;
    bad = 0;
    while (!ce_1 && n < 1000) begin
      step();
      n++;
      if (cfg_ready || !cfg_pending) bad++;
    end
    chk("pend.c1", 32'(ce_1), 1);
    chk("pend.hs", 32'(bad), 0);
    step();
    chk("apply.pnd", 32'(cfg_pending), 0);
    chk("apply.rdy", 32'(cfg_ready), 1);
    chk("apply.ph", 32'(phase), 0);
    novs = 0;
    nc1  = 0;
    n    = 0;
    for (int i = 1; i <= 15625; i++) begin
      step();
      if (ce_ovs && n == 0) n = i;
      if (ce_ovs) novs++;
      if (ce_1) nc1++;
    end
    chk("fast.lat", 32'(n), 14);
    chk("fast.ovs", 32'(novs), 1152);
    chk("fast.c1", 32'(nc1), 72);

    // sync pulse at phase 7
    do_reset();
    load_run(576, 15049);
    wait_phase(7, 400, "sync.wait");
    sync = 1'b1;
    step();
    sync = 1'b0;
`ifdef BAUD_GEN_SYNC_EN
    chk("sync.ph", 32'(phase), 0);
    chk("sync.ovs", 32'(ce_ovs), 0);
    chk("sync.c1", 32'(ce_1), 0);
    n = 0;
    while (!ce_ovs && n < 100) begin
      step();
      n++;
    end
    chk("sync.lat", 32'(n), 28);
`else
    ph0 = PW'(7) + PW'(ce_ovs);
    chk("nosync.ph", 32'(phase), 32'(ph0));
    step();
    chk("nosync.ph2", 32'(phase != 0), 1);
`endif

    // reset while a pair is pending
    cfg_valid = 1'b1;
    cfg_freq  = FW'(1152);
    cfg_limit = LW'(14473);
    step();
    cfg_valid = 1'b0;
    chk("prst.pnd0", 32'(cfg_pending), 1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("prst.pnd", 32'(cfg_pending), 0);
    chk("prst.rdy", 32'(cfg_ready), 1);
    chk("prst.ovs", 32'(ce_ovs), 0);
    chk("prst.c1", 32'(ce_1), 0);
    chk("prst.ph", 32'(phase), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
